bitmap_write_ctrl: RTL and testbench
====================================

// Module: bitmap_write_ctrl
// PURPOSE
//  Owns the single write port of the character bitmap RAM and shares it between two requesters.
//  - CPU single-byte writes.
//  - Glyph fill engine: writes one 8-bit pattern into all 16 rows of one character.
//  Sits between the CPU bus decode and the bitmap RAM; write outputs connect directly to its write port.
// PARAMETERS
//  CHAR_W  7  character index width (lower-128 ASCII)
//  ROW_W   4  glyph row index width (16 rows/glyph)
//  DATA_W  8  bitmap row width (pixels per row)
// PORTS
//  CLK           in   1            system clock, all logic on posedge
//  RST           in   1            synchronous, active-high reset
//  cpu_valid     in   1            CPU write request
//  cpu_ready     out  1            CPU write accepted when cpu_valid&&cpu_ready
//  cpu_addr      in   CHAR_W+ROW_W {char,row} byte address
//  cpu_data      in   DATA_W       row data
//  fill_valid    in   1            glyph fill request
//  fill_ready    out  1            fill accepted when fill_valid&&fill_ready
//  fill_char     in   CHAR_W       glyph to fill
//  fill_pattern  in   DATA_W       byte written to every row
//  fill_busy     out  1            fill in progress
//  fill_done     out  1            1-cycle pulse, last fill row issued
//  write_data    out  DATA_W       to bitmap RAM write_data
//  write_addr    out  CHAR_W+ROW_W to bitmap RAM write_addr
//  write_strobe  out  1            to bitmap RAM write_strobe
// BEHAVIOUR
//  - Reset: state IDLE, row=0, rr=CPU; write_strobe/addr/data=0, fill_done=0, fill_busy=0.
//  - Write outputs are registered. A granted write appears on write_* the cycle after grant.
//  - At most one write_strobe per cycle.
//  - FSM IDLE->FILL on fill accept; FILL->IDLE after row 15 is issued.
//  - fill_ready = (state==IDLE); fill_busy = (state==FILL).
//  - On fill accept: latch fill_char/fill_pattern, row=0.
//  - IDLE: cpu_ready=1.
//    - A CPU write and a fill accepted in the same cycle are both taken.
//    - The CPU write issues next cycle; fill rows start the cycle after acceptance.
//  - FILL arbitration is round-robin between CPU and fill, pointer rr:
//    - cpu_ready = (rr==CPU); it depends on state/rr only, never on cpu_valid.
//    - CPU accepted: issue CPU write, rr<=FILL, row held.
//    - Otherwise: issue row {char,row} with pattern, row++, rr<=CPU.
//    - Worst-case fill = 32 cycles; a CPU write waits at most 1 cycle.
//  - Row 15 issued: fill_done=1 with that strobe; state<=IDLE, row<=0, rr<=CPU.
//  - Row counter does not wrap; the transition out of FILL is on row==15.
//  - Overlapping addresses: RAM sees writes in grant order (last grant wins).
//  - Reset mid-fill aborts the fill. Rows already written stay in RAM; no fill_done.
//  - fill_valid during FILL is ignored (fill_ready=0); the requester holds it.
// CONFIGURATION
//  - BITMAP_CTRL_FILL_EN defined: fill engine and arbitration as above.
//  - Not defined: no FILL state.
//    - fill_ready=0, fill_busy=0, fill_done=0; fill_* inputs unused.
//    - cpu_ready=1 constantly; every CPU write issues 1 cycle later.
// STRUCTURE
//  - Package bitmap_pkg holds:
//    - widths CHAR_W, ROW_W, DATA_W, ADDR_W=CHAR_W+ROW_W;
//    - state enum {ST_IDLE, ST_FILL};
//    - rr enum {RR_CPU, RR_FILL}.
//  - One sub-module, bitmap_fill_seq, holds the FSM, row counter, latched char/pattern and fill_done.
//    - It exposes row_valid/row_addr/row_data and takes row_take from the arbiter.
//  - Top holds the arbiter and the output registers.
// TESTING
//  - Reset: assert RST 2 cycles mid-traffic -> all outputs 0, fill_ready=1, cpu_ready=1.
//  - CPU only: write 0x123<=0xA5 -> next cycle strobe=1, addr=0x123, data=0xA5, 1 cycle.
//  - Fill only: char 0x41, pattern 0xFF.
//    - 16 consecutive strobes, addr 0x410..0x41F.
//    - fill_done high with 0x41F only; fill_busy low next cycle.
//  - Fill with cpu_valid held high (addr 0x7F0, data 0x3C):
//    - strobes alternate CPU/fill; fill completes in 32 cycles;
//    - cpu_ready never low 2 cycles in a row.
//  - Simultaneous accept in IDLE: CPU 0x002<=0x11 and fill char 0 pattern 0x00.
//    - CPU strobe first, then rows 0x000..0x00F; RAM[0x002] ends 0x00.
//  - Reset at row 5 of a fill: no fill_done; strobes stop; fill_ready=1 after reset.
//  - Rebuild without BITMAP_CTRL_FILL_EN:
//    - fill_valid=1 -> fill_ready=0, no fill strobes;
//    - CPU writes every cycle accepted.

Source files
------------

// File: rtl/bitmap_pkg.sv
// Shared widths, state/arbiter encodings and address helper for the bitmap write controller.
package bitmap_pkg;

    localparam int CHAR_W = 7;
    localparam int ROW_W  = 4;
    localparam int DATA_W = 8;
    localparam int ADDR_W = CHAR_W + ROW_W;

    localparam logic [ROW_W-1:0] LAST_ROW = '1;

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    typedef enum logic {
        RR_CPU,
        RR_FILL
    } rr_t;

    // Byte address of one glyph row: the character selects a 16-row block.
    function automatic logic [ADDR_W-1:0] glyph_addr(
        input logic [CHAR_W-1:0] char_idx,
        input logic [ROW_W-1:0]  row_idx
    );
        return {char_idx, row_idx};
    endfunction

endpackage

// File: rtl/bitmap_write_ctrl_if.sv
// Request/response and RAM write bundle of the bitmap write controller.
interface bitmap_write_ctrl_if;
    import bitmap_pkg::*;

    logic              cpu_valid;
    logic              cpu_ready;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_data;

    logic              fill_valid;
    logic              fill_ready;
    logic [CHAR_W-1:0] fill_char;
    logic [DATA_W-1:0] fill_pattern;
    logic              fill_busy;
    logic              fill_done;

    logic [DATA_W-1:0] write_data;
    logic [ADDR_W-1:0] write_addr;
    logic              write_strobe;

    modport master (
        output cpu_valid, cpu_addr, cpu_data,
        output fill_valid, fill_char, fill_pattern,
        input  cpu_ready, fill_ready, fill_busy, fill_done,
        input  write_data, write_addr, write_strobe
    );

    modport slave (
        input  cpu_valid, cpu_addr, cpu_data,
        input  fill_valid, fill_char, fill_pattern,
        output cpu_ready, fill_ready, fill_busy, fill_done,
        output write_data, write_addr, write_strobe
    );

endinterface

// File: rtl/bitmap_fill_seq.sv
// Glyph fill sequencer: FSM, row counter, latched char/pattern and the fill_done pulse.
module bitmap_fill_seq
    import bitmap_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              fill_valid,
    input  logic [CHAR_W-1:0] fill_char,
    input  logic [DATA_W-1:0] fill_pattern,
    input  logic              row_take,
    output logic              fill_ready,
    output logic              fill_busy,
    output logic              fill_done,
    output logic              row_valid,
    output logic [ADDR_W-1:0] row_addr,
    output logic [DATA_W-1:0] row_data
);

    state_t            state_reg,   state_next;
    logic [ROW_W-1:0]  row_reg,     row_next;
    logic [CHAR_W-1:0] char_reg,    char_next;
    logic [DATA_W-1:0] pattern_reg, pattern_next;
    logic              done_reg,    done_next;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= ST_IDLE;
            row_reg     <= '0;
            char_reg    <= '0;
            pattern_reg <= '0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            row_reg     <= row_next;
            char_reg    <= char_next;
            pattern_reg <= pattern_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        row_next     = row_reg;
        char_next    = char_reg;
        pattern_next = pattern_reg;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (fill_valid) begin
                    state_next   = ST_FILL;
                    row_next     = '0;
                    char_next    = fill_char;
                    pattern_next = fill_pattern;
                end
            end
            ST_FILL: begin
                if (row_take) begin
                    // The done pulse is registered so it lines up with the last row's strobe.
                    if (row_reg == LAST_ROW) begin
                        state_next = ST_IDLE;
                        row_next   = '0;
                        done_next  = 1'b1;
                    end else begin
                        row_next = row_reg + 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign fill_ready = (state_reg == ST_IDLE);
    assign fill_busy  = (state_reg == ST_FILL);
    assign fill_done  = done_reg;
    assign row_valid  = (state_reg == ST_FILL);
    assign row_addr   = glyph_addr(char_reg, row_reg);
    assign row_data   = pattern_reg;

endmodule

// File: rtl/bitmap_write_ctrl.sv
// Bitmap RAM write-port owner: CPU/fill round-robin arbiter and registered write outputs.
// Fill engine is present only when BITMAP_CTRL_FILL_EN is defined.
module bitmap_write_ctrl
    import bitmap_pkg::*;
(
    input  logic                CLK,
    input  logic                RST,
    bitmap_write_ctrl_if.slave  bus
);

    logic              cpu_grant;
    logic              row_valid;
    logic              row_take;
    logic [ADDR_W-1:0] row_addr;
    logic [DATA_W-1:0] row_data;

    logic              write_strobe_reg;
    logic [ADDR_W-1:0] write_addr_reg;
    logic [DATA_W-1:0] write_data_reg;

`ifdef BITMAP_CTRL_FILL_EN
    rr_t  rr_reg, rr_next;
    logic cpu_ready_w;

    bitmap_fill_seq u_fill_seq (
        .CLK          (CLK),
        .RST          (RST),
        .fill_valid   (bus.fill_valid),
        .fill_char    (bus.fill_char),
        .fill_pattern (bus.fill_pattern),
        .row_take     (row_take),
        .fill_ready   (bus.fill_ready),
        .fill_busy    (bus.fill_busy),
        .fill_done    (bus.fill_done),
        .row_valid    (row_valid),
        .row_addr     (row_addr),
        .row_data     (row_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_reg <= RR_CPU;
        end else begin
            rr_reg <= rr_next;
        end
    end

    // cpu_ready is a function of state and pointer only, so the CPU never sees a combinational loop.
    always_comb begin
        cpu_ready_w = !row_valid || (rr_reg == RR_CPU);
        cpu_grant   = bus.cpu_valid && cpu_ready_w;
        row_take    = row_valid && !cpu_grant;
        rr_next     = rr_reg;
        if (row_valid) begin
            rr_next = cpu_grant ? RR_FILL : RR_CPU;
        end
    end

    assign bus.cpu_ready = cpu_ready_w;
`else
    logic unused_fill_inputs;

    assign unused_fill_inputs = ^{bus.fill_valid, bus.fill_char, bus.fill_pattern};
    assign row_valid      = 1'b0;
    assign row_take       = 1'b0;
    assign row_addr       = '0;
    assign row_data       = '0;
    assign cpu_grant      = bus.cpu_valid;
    assign bus.cpu_ready  = 1'b1;
    assign bus.fill_ready = 1'b0;
    assign bus.fill_busy  = 1'b0;
    assign bus.fill_done  = 1'b0;
`endif

    // Address/data hold their last value between strobes; only the strobe qualifies them.
    always_ff @(posedge CLK) begin
        if (RST) begin
            write_strobe_reg <= 1'b0;
            write_addr_reg   <= '0;
            write_data_reg   <= '0;
        end else begin
            write_strobe_reg <= cpu_grant || row_take;
            if (cpu_grant) begin
                write_addr_reg <= bus.cpu_addr;
                write_data_reg <= bus.cpu_data;
            end else if (row_take) begin
                write_addr_reg <= row_addr;
                write_data_reg <= row_data;
            end
        end
    end

    assign bus.write_strobe = write_strobe_reg;
    assign bus.write_addr   = write_addr_reg;
    assign bus.write_data   = write_data_reg;

endmodule

// File: tb/tb_bitmap_write_ctrl.sv
// Scoreboard bench for bitmap_write_ctrl; adapts expectations to BITMAP_CTRL_FILL_EN.
module tb_bitmap_write_ctrl;
    import bitmap_pkg::*;

`ifdef BITMAP_CTRL_FILL_EN
    localparam bit FILL_EN = 1'b1;
`else
    localparam bit FILL_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;

    bitmap_write_ctrl_if bus ();

    bitmap_write_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              done;
        int                due;
    } wr_t;

    wr_t               exp_q[$];
    logic [ADDR_W-1:0] fill_rows_q[$];
    logic [DATA_W-1:0] fill_pat;
    bit                cpu_turn = 1'b1;
    logic [DATA_W-1:0] ram_dut   [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_model [0:(1<<ADDR_W)-1];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int busy_cnt = 0;
    int low_run  = 0;
    int max_low  = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic done);
        wr_t w;
        w.addr = a;
        w.data = d;
        w.done = done;
        w.due  = cyc + 1;
        exp_q.push_back(w);
        ram_model[a] = d;
    endtask

    // Monitor: every strobe is matched against the next expected write, in grant order.
    always @(negedge CLK) begin
        wr_t e;
        if (bus.write_strobe === 1'b1) begin
            ram_dut[bus.write_addr] = bus.write_data;
            $display("wr cyc=%0d addr=0x%03h data=0x%02h done=%0b",
                     cyc, bus.write_addr, bus.write_data, bus.fill_done);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.write_addr), 32'(e.addr));
                check("wr_data", 32'(bus.write_data), 32'(e.data));
                check("wr_done", 32'(bus.fill_done),  32'(e.done));
                check("wr_cycle", cyc, e.due);
            end
        end else begin
            if (bus.fill_done === 1'b1) check("done_without_strobe", 32'd1, 32'd0);
            if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                check("missing_strobe", 32'(e.addr), 32'hFFFF_FFFF);
            end
        end
    end

    // One clock of stimulus plus the reference model's view of what that cycle grants.
    task automatic drive(input bit cv, input logic [ADDR_W-1:0] ca, input logic [DATA_W-1:0] cd,
                         input bit fv, input logic [CHAR_W-1:0] fc, input logic [DATA_W-1:0] fp,
                         input bit rst);
        bit idle;
        logic [ADDR_W-1:0] a;
        @(negedge CLK);
        #1;
        bus.cpu_valid    = cv;
        bus.cpu_addr     = ca;
        bus.cpu_data     = cd;
        bus.fill_valid   = fv;
        bus.fill_char    = fc;
        bus.fill_pattern = fp;
        RST              = rst;
        #1;
        if (rst) begin
            exp_q.delete();
            fill_rows_q.delete();
            cpu_turn = 1'b1;
            low_run  = 0;
        end else begin
            idle = (fill_rows_q.size() == 0);
            check("cpu_ready",  32'(bus.cpu_ready),  32'(idle || cpu_turn));
            check("fill_ready", 32'(bus.fill_ready), 32'(FILL_EN && idle));
            check("fill_busy",  32'(bus.fill_busy),  32'(!idle));
            if (bus.fill_busy === 1'b1) busy_cnt++;
            if (bus.cpu_ready === 1'b0) begin
                low_run++;
                if (low_run > max_low) max_low = low_run;
            end else begin
                low_run = 0;
            end
            if (idle) begin
                if (cv) push_write(ca, cd, 1'b0);
                if (fv && FILL_EN) begin
                    for (int r = 0; r < 16; r++) fill_rows_q.push_back({fc, 4'(r)});
                    fill_pat = fp;
                    cpu_turn = 1'b1;
                end
            end else if (cv && cpu_turn) begin
                push_write(ca, cd, 1'b0);
                cpu_turn = 1'b0;
            end else begin
                a = fill_rows_q.pop_front();
                push_write(a, fill_pat, fill_rows_q.size() == 0);
                cpu_turn = 1'b1;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic reset_and_check(input string tag);
        for (int i = 0; i < 2; i++)
            drive(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
                  1'($urandom_range(0, 1)), CHAR_W'($urandom), DATA_W'($urandom), 1'b1);
        @(negedge CLK);
        #1;
        check({tag, "_strobe"},     32'(bus.write_strobe), 32'd0);
        check({tag, "_addr"},       32'(bus.write_addr),   32'd0);
        check({tag, "_data"},       32'(bus.write_data),   32'd0);
        check({tag, "_done"},       32'(bus.fill_done),    32'd0);
        check({tag, "_busy"},       32'(bus.fill_busy),    32'd0);
        check({tag, "_cpu_ready"},  32'(bus.cpu_ready),    32'd1);
        check({tag, "_fill_ready"}, 32'(bus.fill_ready),   32'(FILL_EN));
    endtask

    initial begin
        bus.cpu_valid    = 1'b0;
        bus.cpu_addr     = '0;
        bus.cpu_data     = '0;
        bus.fill_valid   = 1'b0;
        bus.fill_char    = '0;
        bus.fill_pattern = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            ram_dut[i]   = '0;
            ram_model[i] = '0;
        end

        reset_and_check("reset0");

        // Single CPU write
        drive(1'b1, 11'h123, 8'hA5, 1'b0, '0, '0, 1'b0);
        idle_cycles(3);

        // Plain glyph fill
        drive(1'b0, '0, '0, 1'b1, 7'h41, 8'hFF, 1'b0);
        idle_cycles(20);

        // Fill with the CPU hammering the port
        busy_cnt = 0;
        max_low  = 0;
        low_run  = 0;
        drive(1'b0, '0, '0, 1'b1, 7'h20, 8'h5A, 1'b0);
        for (int i = 0; i < 34; i++) drive(1'b1, 11'h7F0, 8'h3C, 1'b0, '0, '0, 1'b0);
        check("fill_len_cycles",   busy_cnt, FILL_EN ? 32'd32 : 32'd0);
        check("cpu_ready_low_run", 32'(max_low <= 1), 32'd1);
        idle_cycles(3);

        // Simultaneous CPU and fill accept; the fill overwrites the CPU byte
        drive(1'b1, 11'h002, 8'h11, 1'b1, 7'h00, 8'h00, 1'b0);
        idle_cycles(20);
        check("ram_002", 32'(ram_dut[2]), 32'(ram_model[2]));

        // Reset after five rows of a fill
        drive(1'b0, '0, '0, 1'b1, 7'h55, 8'hC3, 1'b0);
        idle_cycles(5);
        reset_and_check("reset_mid_fill");
        idle_cycles(20);

        // Fill requests held during another fill are ignored
        drive(1'b0, '0, '0, 1'b1, 7'h10, 8'h81, 1'b0);
        for (int i = 0; i < 20; i++) drive(1'b0, '0, '0, 1'b1, 7'h11, 8'h18, 1'b0);
        idle_cycles(3);

        // Randomised traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ADDR_W'($urandom), DATA_W'($urandom),
                  ($urandom_range(0, 7) == 0), CHAR_W'($urandom), DATA_W'($urandom),
                  ($urandom_range(0, 149) == 0));
        end
        idle_cycles(40);
        check("drain_empty", exp_q.size(), 32'd0);

        for (int a = 0; a < 16; a++) check("ram_glyph_41", 32'(ram_dut[{7'h41, 4'(a)}]),
                                           32'(ram_model[{7'h41, 4'(a)}]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
